// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle over 32 cycles; sign fix-up applied on the final step.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        abort,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        is_div_q, neg_res_q, neg_rem_q;
  logic [31:0] m_q, acc_hi_q, acc_lo_q, hi_q, lo_q;

  logic        sgn, a_neg, b_neg, last;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum;
  logic [33:0] diff;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod, prod_s;
  logic [31:0] quot_s, rem_s;

  assign sgn   = ~op[0];
  assign a_neg = sgn & src_a[31];
  assign b_neg = sgn & src_b[31];
  assign a_mag = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag = b_neg ? (~src_b + 32'd1) : src_b;
  assign last  = (state_q == CALC) && (cnt_q == 5'd31);

  // Multiply: {acc_hi,acc_lo} shift right with add. Divide: acc_hi = partial remainder, acc_lo = dividend/quotient.
  always_comb begin
    sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : 33'd0);
    diff = {1'b0, acc_hi_q, acc_lo_q[31]} - {2'b00, m_q};
    if (is_div_q) begin
      if (!diff[33]) begin
        step_hi = diff[31:0];
        step_lo = {acc_lo_q[30:0], 1'b1};
      end else begin
        step_hi = {acc_hi_q[30:0], acc_lo_q[31]};
        step_lo = {acc_lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi = sum[32:1];
      step_lo = {sum[0], acc_lo_q[31:1]};
    end
  end

  assign prod   = {step_hi, step_lo};
  assign prod_s = neg_res_q ? (~prod + 64'd1) : prod;
  assign quot_s = neg_res_q ? (~step_lo + 32'd1) : step_lo;
  assign rem_s  = neg_rem_q ? (~step_hi + 32'd1) : step_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (abort) state_d = IDLE;
               else if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divide by zero needs no special case: restoring division yields an all-ones
  // quotient and remainder = |dividend|; quotient negation is suppressed and the
  // remainder sign restores the original dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      m_q       <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
    end else if (state_q == IDLE && start) begin
      cnt_q     <= 5'd0;
      is_div_q  <= op[1];
      neg_res_q <= (a_neg ^ b_neg) & (~op[1] | (|src_b));
      neg_rem_q <= a_neg;
      m_q       <= op[1] ? b_mag : a_mag;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= op[1] ? a_mag : b_mag;
    end else if (state_q == CALC) begin
      cnt_q    <= cnt_q + 5'd1;
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state_q == IDLE) begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
    end else if (last && !abort) begin
      hi_q <= is_div_q ? rem_s  : prod_s[63:32];
      lo_q <= is_div_q ? quot_s : prod_s[31:0];
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic vectors, latency, HI/LO writes, abort and reset.
module tb_mul_div_unit;
  logic        clk, rst_n, start, abort, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata, hi, lo;
  logic        busy, done;

  int vecs = 0;
  int errs = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start an op, wait for done (bounded). lat counts edges from the start edge (=1).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic pbusy, output logic pdone);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rhi = hi; rlo = lo;
    @(posedge clk); #1;
    pbusy = busy; pdone = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; abort = 0; hi_we = 0; lo_we = 0;
    op = 2'b00; src_a = 0; src_b = 0; wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errs++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, need 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_arith;
    logic [1:0]  ops [10] = '{MULT, MULTU, MULT, MULT, DIV, DIV, DIVU, DIV, DIV, DIVU};
    logic [31:0] as  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd7, 32'hFFFFFFF9,
                              32'd7, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs  [10] = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd2,
                              32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h10};
    logic [31:0] ehi [10] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd1, 32'd7, 32'hFFFFFFF9, 32'd0, 32'hF};
    logic [31:0] elo [10] = '{32'hFFFFFFF1, 32'h00000001, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFD,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0FFFFFFF};
    int lat; logic [31:0] rhi, rlo; logic pb, pd;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], lat, rhi, rlo, pb, pd);
      vecs++;
      if (lat !== 33 || rhi !== ehi[i] || rlo !== elo[i]) begin
        errs++;
        $display("FAIL arith[%0d]: lat=%0d hi=%h lo=%h, need lat=33 hi=%h lo=%h",
                 i, lat, rhi, rlo, ehi[i], elo[i]);
      end
      vecs++;
      if (pb !== 1'b0 || pd !== 1'b0) begin
        errs++;
        $display("FAIL done_pulse[%0d]: busy=%b done=%b after done cycle, need 0/0", i, pb, pd);
      end
    end
  endtask

  task automatic test_mthi_mtlo;
    int lat; logic [31:0] rhi, rlo; logic pb, pd;
    @(negedge clk); hi_we = 1; wdata = 32'hA5A5_0001;
    @(posedge clk); #1; hi_we = 0;
    @(negedge clk); lo_we = 1; wdata = 32'h5A5A_0002;
    @(posedge clk); #1; lo_we = 0;
    vecs++;
    if (hi !== 32'hA5A5_0001 || lo !== 32'h5A5A_0002) begin
      errs++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h, need a5a50001/5a5a0002", hi, lo);
    end
    // start and HI/LO write in the same IDLE cycle: write lands, then result overwrites
    @(negedge clk);
    op = MULTU; src_a = 3; src_b = 4; start = 1; hi_we = 1; lo_we = 1; wdata = 32'h5555;
    @(posedge clk); #1;
    start = 0; hi_we = 0; lo_we = 0;
    vecs++;
    if (hi !== 32'h5555 || lo !== 32'h5555 || busy !== 1'b1) begin
      errs++;
      $display("FAIL start_and_write: hi=%h lo=%h busy=%b, need 5555/5555/1", hi, lo, busy);
    end
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    vecs++;
    if (lat !== 33 || hi !== 32'd0 || lo !== 32'd12) begin
      errs++;
      $display("FAIL start_and_write_result: lat=%0d hi=%h lo=%h, need 33/0/c", lat, hi, lo);
    end
    @(posedge clk); #1;
    run_op(MULTU, 32'd1, 32'd1, lat, rhi, rlo, pb, pd);
  endtask

  task automatic test_abort;
    logic seen_done;
    int lat;
    @(negedge clk); hi_we = 1; lo_we = 1; wdata = 32'h1234;
    @(posedge clk); #1; hi_we = 0; lo_we = 0;
    @(negedge clk); op = DIVU; src_a = 100; src_b = 3; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (9) @(posedge clk);
    @(negedge clk); abort = 1; hi_we = 1; wdata = 32'hDEAD;
    @(posedge clk); #1; abort = 0; hi_we = 0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h1234 || lo !== 32'h1234) begin
      errs++;
      $display("FAIL abort_mid: busy=%b done=%b hi=%h lo=%h, need 0/0/1234/1234", busy, done, hi, lo);
    end
    seen_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen_done = 1; end
    vecs++;
    if (seen_done !== 1'b0 || hi !== 32'h1234) begin
      errs++;
      $display("FAIL abort_no_done: done_seen=%b hi=%h, need 0/1234", seen_done, hi);
    end
    // abort on the final-iteration edge beats the result write
    @(negedge clk); op = MULTU; src_a = 9; src_b = 9; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (31) @(posedge clk);
    @(negedge clk); abort = 1;
    @(posedge clk); #1; abort = 0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h1234 || lo !== 32'h1234) begin
      errs++;
      $display("FAIL abort_last: busy=%b done=%b hi=%h lo=%h, need 0/0/1234/1234", busy, done, hi, lo);
    end
    // abort in IDLE does not block start
    @(negedge clk); op = DIVU; src_a = 100; src_b = 3; start = 1; abort = 1;
    @(posedge clk); #1; start = 0; abort = 0;
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_idle: busy=%b, need 1", busy);
    end
    // re-pulsed start and writes while busy are ignored
    repeat (4) @(posedge clk);
    @(negedge clk); op = MULT; src_a = 5; src_b = 5; start = 1; lo_we = 1; wdata = 32'hBAD;
    @(posedge clk); #1; start = 0; lo_we = 0;
    lat = 6;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    vecs++;
    if (lat !== 33 || lo !== 32'd33 || hi !== 32'd1) begin
      errs++;
      $display("FAIL busy_ignore: lat=%0d hi=%h lo=%h, need 33/1/21", lat, hi, lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rhi, rlo; logic pb, pd;
    @(negedge clk); op = MULTU; src_a = 32'hFFFFFFFF; src_b = 2; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (19) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errs++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, need 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(MULT, 32'd6, 32'd7, lat, rhi, rlo, pb, pd);
    vecs++;
    if (lat !== 33 || rhi !== 32'd0 || rlo !== 32'd42) begin
      errs++;
      $display("FAIL after_reset: lat=%0d hi=%h lo=%h, need 33/0/2a", lat, rhi, rlo);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mthi_mtlo();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL expose: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL expose: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: start  in  1  request new operation; sampled only in IDLE.
REQ-004 SHALL expose: op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL expose: src_a  in  32  multiplicand / dividend.
REQ-006 SHALL expose: src_b  in  32  multiplier / divisor.
REQ-007 SHALL expose: abort  in  1  synchronous cancel of the operation in flight (pipeline flush).
REQ-008 SHALL expose: hi_we, lo_we  in  1 each  MTHI/MTLO write enables.
REQ-009 SHALL expose: wdata  in  32  MTHI/MTLO write data.
REQ-010 SHALL expose: busy  out  1  high while state != IDLE; used by hazard logic to stall.
REQ-011 SHALL expose: done  out  1  one-cycle completion pulse.
REQ-012 SHALL expose: hi, lo  out  32 each  HI/LO register contents, feeding the writeback result select mux.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 IDLE -> CALC on a clock edge with start=1: latch op, operand magnitudes, and result sign; clear the iteration counter to 0.
REQ-015 CALC SHALL perform one radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide, on 32-bit unsigned magnitudes.
REQ-016 CALC SHALL last exactly 32 cycles (counter 0..31); on the edge with counter=31, write the sign-corrected result into hi/lo and enter DONE.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-018 Latency: start accepted at edge E0; busy=1 for the 33 cycles after E0; done and new hi/lo are visible in cycle 33.
REQ-019 MULT/MULTU: {hi,lo} SHALL hold the full 64-bit signed/unsigned product.
REQ-020 DIV/DIVU: lo SHALL hold the quotient truncated toward zero; hi SHALL hold the remainder, which takes the dividend's sign.
REQ-021 Divide by zero (any sign): lo SHALL be 0xFFFFFFFF and hi SHALL be src_a unchanged; latency is unchanged.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000 (wrap, no trap).
REQ-023 start while busy=1 SHALL be ignored; operand inputs SHALL NOT affect an operation in flight.
REQ-024 In IDLE, hi_we/lo_we SHALL load wdata into hi/lo on the next edge.
REQ-025 While busy=1, hi_we/lo_we SHALL be ignored.
REQ-026 If start and hi_we/lo_we are asserted in the same IDLE cycle, both SHALL take effect; the operation result later overwrites hi/lo.
REQ-027 abort=1 in CALC or DONE SHALL force IDLE on the next edge.
REQ-028 On that abort, hi/lo SHALL be left at their pre-operation values and done SHALL NOT pulse; if the abort edge coincides with the counter=31 edge, abort SHALL win.
REQ-029 abort in IDLE SHALL have no effect and SHALL NOT block a start in the same cycle.

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0 and all internal datapath registers to 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation; after release the block SHALL accept start on the first edge.

Verification
REQ-032 MULT src_a=0xFFFFFFFD (-3), src_b=5 -> done in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-035 Preload hi=0x1234 via hi_we, start DIVU 100/3, assert abort in cycle 10 -> busy=0 by cycle 11, no done pulse, hi=0x1234 retained; start re-pulsed while busy on a later op -> ignored.
REQ-036 rst_n pulsed low in cycle 20 of a MULTU -> hi=lo=0 and busy=0 immediately; new MULT 6x7 after release -> lo=42, hi=0.
